// File: rtl/pdm_capture_mc_if.sv
// Sample-buffer write port of the PDM capture engine: packed word, strobe, address, channel.
// The master drives all four signals; nothing flows back, so the buffer must accept every strobe.
interface pdm_capture_mc_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 17
);
  logic [WORD_W-1:0] pdm;
  logic              RW;
  logic [ADDR_W-1:0] didx;
  logic              ch;

  modport master (output pdm, RW, didx, ch);
  modport slave  (input  pdm, RW, didx, ch);
endinterface

// File: rtl/pdm_capture_mc.sv
// PDM capture: generates pdm_clk_o, samples 1-2 channels on opposite phases, packs words MSB-first.
// A word is written one cycle after its last bit is sampled; no backpressure, the buffer must take every write.
module pdm_capture_mc #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 17,
  parameter int NCH    = 2,
  parameter int DIV    = 2
) (
  input  logic              ahb_clk,
  input  logic              rst,
  input  logic [1:0]        ctrl,
  input  logic [ADDR_W-1:0] len,
  input  logic              pdm_signal,
  output logic              pdm_clk_o,
  output logic              bsy,
  output logic              done,
  pdm_capture_mc_if.master  wr
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(WORD_W);
  localparam logic [DW-1:0]     DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0]     BIT_LAST = CW'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              clk_q, clk_d;
  logic [WORD_W-1:0] sh_q [2];
  logic [WORD_W-1:0] sh_d [2];
  logic [CW-1:0]     bit_q [2];
  logic [CW-1:0]     bit_d [2];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              skip_q, skip_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] pdm_q, pdm_d;
  logic              ch_q, ch_d;
  logic [ADDR_W-1:0] didx_q, didx_d;
  logic              done_q, done_d;
  logic              take;
  logic              sel;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    clk_d   = clk_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    len_d   = len_q;
    skip_d  = skip_q;
    wr_d    = 1'b0;
    pdm_d   = pdm_q;
    ch_d    = ch_q;
    didx_d  = didx_q;
    done_d  = 1'b0;
    take    = 1'b0;
    sel     = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        clk_d = 1'b0;
        if (ctrl[0]) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            len_d   = len;
            addr_d  = '0;
            sh_d    = '{default: '0};
            bit_d   = '{default: '0};
            skip_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          clk_d = ~clk_q;
          if (clk_q) begin
            take = 1'b1;
          end else if (NCH == 2) begin
            // The first rising edge of a run has no preceding falling edge, so its ch1 bit is dropped.
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              take = 1'b1;
              sel  = 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end

        if (take) begin
          sh_d[sel] = {sh_q[sel][WORD_W-2:0], pdm_signal};
          if (bit_q[sel] == BIT_LAST) begin
            bit_d[sel] = '0;
            wr_d       = 1'b1;
            pdm_d      = sh_d[sel];
            ch_d       = sel;
            didx_d     = addr_q;
            addr_d     = addr_q + ADDR_ONE;
          end else begin
            bit_d[sel] = bit_q[sel] + 1'b1;
          end
        end

        if (wr_q && (didx_q == len_q - ADDR_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          div_d   = '0;
          clk_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ctrl[1]) begin
      state_d = IDLE;
      div_d   = '0;
      clk_d   = 1'b0;
      sh_d    = '{default: '0};
      bit_d   = '{default: '0};
      addr_d  = '0;
      didx_d  = '0;
      skip_d  = 1'b0;
      wr_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge ahb_clk) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      clk_q   <= 1'b0;
      sh_q    <= '{default: '0};
      bit_q   <= '{default: '0};
      addr_q  <= '0;
      len_q   <= '0;
      skip_q  <= 1'b0;
      wr_q    <= 1'b0;
      pdm_q   <= '0;
      ch_q    <= 1'b0;
      didx_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      clk_q   <= clk_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      skip_q  <= skip_d;
      wr_q    <= wr_d;
      pdm_q   <= pdm_d;
      ch_q    <= ch_d;
      didx_q  <= didx_d;
      done_q  <= done_d;
    end
  end

  assign pdm_clk_o = clk_q;
  assign bsy       = (state_q == RUN);
  assign done      = done_q;
  assign wr.pdm    = pdm_q;
  assign wr.RW     = wr_q;
  assign wr.didx   = didx_q;
  assign wr.ch     = ch_q;

endmodule
